// File: rtl/usr_backchannel.sv
// usr_backchannel -- UART back-channel dump engine.
//
// Purpose:
//   Listens for single-byte commands from a UART receiver. It snapshots the data
//   into a shadow register and then streams it out, one byte at a time, to a UART
//   transmitter.
//     0xAB : dump FILE_SIZE_BYTES regfile bytes, address 0 first.
//     0xAC : dump THUNDER_BYTES bytes of the last Thunderbolt packet, byte 0 first.
//   Commands that arrive while a dump is in progress are dropped.
//
// Optional feature (macro BACKCHANNEL_ECHO_EN):
//   When defined, an unrecognised byte received in IDLE is echoed once.
//   When undefined, such bytes are ignored.
//
// Ports:
//   i_clk          : system clock; all logic is on the rising edge.
//   i_rst          : asynchronous, active-low reset.
//   i_rx_dv        : one-cycle strobe; i_rx_byte holds a received byte.
//   i_rx_byte      : received byte.
//   i_reg_vector   : regfile contents; address j is at bits [8j+7:8j].
//   i_thunder_dv   : one-cycle strobe; i_thunder_data holds a new packet.
//   i_thunder_data : packet bytes; byte 0 is at the MSBs.
//   i_tx_active    : transmitter busy.
//   i_tx_done      : one-cycle strobe when the transmitter finishes a byte.
//   o_tx_dv        : one-cycle send request.
//   o_tx_byte      : byte to send.
//   o_busy         : high whenever the FSM is not IDLE.
//   o_dbg_state    : current FSM state (debug).
//
// Transmit handshake:
//   o_tx_dv is a single-cycle request. It is issued only when i_tx_active was low
//   in the cycle before. o_tx_byte is held stable from that request until
//   i_tx_done. Exactly one i_tx_done is awaited per request before the next byte
//   is offered.
module usr_backchannel #(
  parameter int FILE_SIZE_BYTES = 25,
  parameter int THUNDER_BYTES   = 17
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_rx_dv,
  input  logic [7:0]                   i_rx_byte,
  input  logic [8*FILE_SIZE_BYTES-1:0] i_reg_vector,
  input  logic                         i_thunder_dv,
  input  logic [8*THUNDER_BYTES-1:0]   i_thunder_data,
  input  logic                         i_tx_active,
  input  logic                         i_tx_done,
  output logic                         o_tx_dv,
  output logic [7:0]                   o_tx_byte,
  output logic                         o_busy,
  output logic [1:0]                   o_dbg_state
);

  localparam int SHADOW_BYTES = (FILE_SIZE_BYTES > THUNDER_BYTES) ? FILE_SIZE_BYTES : THUNDER_BYTES;
  localparam int CW           = $clog2(SHADOW_BYTES + 1);
  localparam logic [7:0] CMD_REGFILE = 8'hAB;
  localparam logic [7:0] CMD_THUNDER = 8'hAC;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [8*SHADOW_BYTES-1:0]     shadow_q, shadow_d;
  logic [8*THUNDER_BYTES-1:0]    thunder_q, thunder_d;
  logic [CW-1:0]                 idx_q, idx_d;
  logic [CW-1:0]                 count_q, count_d;
  logic                          tx_dv_q, tx_dv_d;
  logic [7:0]                    tx_byte_q, tx_byte_d;
  logic [8*SHADOW_BYTES-1:0]     thunder_ordered;
  logic [CW-1:0]                 idx_inc;

  // A packet arriving in the same cycle as 0xAC must win over the old latch.
  // For that reason, the shadow copy below reads thunder_d rather than thunder_q.
  always_comb begin
    thunder_d = i_thunder_dv ? i_thunder_data : thunder_q;
  end

  // Reverse the packet so that shadow byte k is packet byte k. Both dumps can
  // then walk the shadow with an ascending index.
  always_comb begin
    thunder_ordered = '0;
    for (int k = 0; k < THUNDER_BYTES; k++) begin
      thunder_ordered[8*k +: 8] = thunder_d[8*(THUNDER_BYTES-1-k) +: 8];
    end
  end

  assign idx_inc = idx_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    count_d   = count_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_dv) begin
          if (i_rx_byte == CMD_REGFILE) begin
            shadow_d                         = '0;
            shadow_d[8*FILE_SIZE_BYTES-1:0]  = i_reg_vector;
            count_d                          = CW'(FILE_SIZE_BYTES);
            idx_d                            = '0;
            state_d                          = ST_SEND;
          end else if (i_rx_byte == CMD_THUNDER) begin
            shadow_d = thunder_ordered;
            count_d  = CW'(THUNDER_BYTES);
            idx_d    = '0;
            state_d  = ST_SEND;
          end
`ifdef BACKCHANNEL_ECHO_EN
          else begin
            shadow_d      = '0;
            shadow_d[7:0] = i_rx_byte;
            count_d       = CW'(1);
            idx_d         = '0;
            state_d       = ST_SEND;
          end
`endif
        end
      end
      ST_SEND: begin
        if (!i_tx_active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = shadow_q[{idx_q, 3'b000} +: 8];
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == count_q) ? ST_IDLE : ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      thunder_q <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      thunder_q <= thunder_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_tx_dv     = tx_dv_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_usr_backchannel.sv
// Testbench for usr_backchannel.
//
// The model keeps the regfile and the Thunderbolt latch as byte arrays. Each
// accepted command pushes the bytes it must produce onto exp_q. The
// outstanding-byte count (accepted - done_cnt) defines when the block must
// report busy. A uart_tx model answers every request with i_tx_done 10 cycles
// later.
`timescale 1ns/1ps
module tb_usr_backchannel;
  localparam int FB = 25;
  localparam int TB = 17;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_rx_dv;
  logic [7:0]      i_rx_byte;
  logic [8*FB-1:0] i_reg_vector;
  logic            i_thunder_dv;
  logic [8*TB-1:0] i_thunder_data;
  logic            i_tx_active;
  logic            i_tx_done;
  logic            o_tx_dv;
  logic [7:0]      o_tx_byte;
  logic            o_busy;
  logic [1:0]      o_dbg_state;

  logic uart_busy;
  logic hold_active;
  assign i_tx_active = uart_busy | hold_active;

  usr_backchannel #(.FILE_SIZE_BYTES(FB), .THUNDER_BYTES(TB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .i_reg_vector(i_reg_vector), .i_thunder_dv(i_thunder_dv),
    .i_thunder_data(i_thunder_data), .i_tx_active(i_tx_active),
    .i_tx_done(i_tx_done), .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset block: 10 MHz
  always #50 i_clk = ~i_clk;

  // Model state
  logic [7:0] reg_mem [FB];
  logic [7:0] thunder_latch [TB];
  logic [7:0] pkt_buf [TB];
  logic [7:0] exp_q [$];
  logic [7:0] sent_log [$];
  int         accepted;
  int         done_cnt;
  int         n_tests;
  int         n_fail;
  logic [7:0] last_sent;
  logic       prev_dv;
  logic       prev_active;
  int         uart_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8*FB-1:0] pack_regs();
    logic [8*FB-1:0] v;
    for (int j = 0; j < FB; j++) v[8*j +: 8] = reg_mem[j];
    return v;
  endfunction

  function automatic logic [8*TB-1:0] pack_pkt();
    logic [8*TB-1:0] v;
    for (int k = 0; k < TB; k++) v[8*(TB-1-k) +: 8] = pkt_buf[k];
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic set_regs(input logic [7:0] base);
    for (int j = 0; j < FB; j++) reg_mem[j] = base + 8'(j);
    i_reg_vector = pack_regs();
  endtask

  task automatic thunder_pulse();
    i_thunder_dv   = 1'b1;
    i_thunder_data = pack_pkt();
    tick();
    i_thunder_dv = 1'b0;
    for (int k = 0; k < TB; k++) thunder_latch[k] = pkt_buf[k];
  endtask

  task automatic send_cmd(input logic [7:0] b, input bit with_pkt);
    bit idle;
    idle      = (accepted == done_cnt);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    if (with_pkt) begin
      i_thunder_dv   = 1'b1;
      i_thunder_data = pack_pkt();
    end
    tick();
    i_rx_dv      = 1'b0;
    i_thunder_dv = 1'b0;
    if (with_pkt) for (int k = 0; k < TB; k++) thunder_latch[k] = pkt_buf[k];
    if (idle) begin
      if (b == 8'hAB) begin
        for (int j = 0; j < FB; j++) exp_q.push_back(reg_mem[j]);
        accepted += FB;
      end else if (b == 8'hAC) begin
        for (int k = 0; k < TB; k++) exp_q.push_back(thunder_latch[k]);
        accepted += TB;
      end else begin
`ifdef BACKCHANNEL_ECHO_EN
        exp_q.push_back(b);
        accepted += 1;
`endif
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((accepted != done_cnt || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check(name, (n < 3000), 1'b1);
    repeat (3) tick();
  endtask

  task automatic wait_sent(input int cnt, input string name);
    int n;
    n = 0;
    while (sent_log.size() < cnt && n < 1000) begin
      tick();
      n++;
    end
    check(name, (n < 1000), 1'b1);
  endtask

  initial begin
    int base;
    int n;
    i_rst = 1'b0; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_thunder_dv = 1'b0;
    i_thunder_data = '0; i_reg_vector = '0; i_tx_done = 1'b0;
    uart_busy = 1'b0; hold_active = 1'b0; accepted = 0; done_cnt = 0;
    n_tests = 0; n_fail = 0; last_sent = 8'h00; prev_dv = 1'b0; prev_active = 1'b0;
    uart_cnt = 0;
    for (int k = 0; k < TB; k++) thunder_latch[k] = 8'h00;

    fork
      // uart_tx model: accept a request and finish it 10 cycles later
      forever begin
        @(posedge i_clk);
        #1;
        if (i_tx_done) done_cnt++;
        i_tx_done = 1'b0;
        if (!i_rst) begin
          uart_busy = 1'b0;
          uart_cnt  = 0;
        end else if (uart_busy) begin
          uart_cnt--;
          if (uart_cnt == 0) begin
            i_tx_done = 1'b1;
            uart_busy = 1'b0;
          end
        end else if (o_tx_dv) begin
          uart_busy = 1'b1;
          uart_cnt  = 10;
        end
      end
      // Scoreboard: compare DUT outputs against the model on every cycle
      forever begin
        @(negedge i_clk);
        if (i_rst) begin
          check("busy", o_busy, (accepted != done_cnt));
          if (o_tx_dv) begin
            check("dv_back_to_back", prev_dv, 1'b0);
            check("dv_while_active", prev_active, 1'b0);
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_tx: got byte 0x%0h, expected no transmit", o_tx_byte);
            end else begin
              check("tx_byte", o_tx_byte, exp_q.pop_front());
            end
            sent_log.push_back(o_tx_byte);
            last_sent = o_tx_byte;
          end else if (uart_busy) begin
            check("tx_byte_hold", o_tx_byte, last_sent);
          end
          prev_dv     = o_tx_dv;
          prev_active = i_tx_active;
        end else begin
          prev_dv     = 1'b0;
          prev_active = 1'b0;
        end
      end
    join_none

    // Reset values
    repeat (3) tick();
    check("rst_tx_dv", o_tx_dv, 1'b0);
    check("rst_tx_byte", o_tx_byte, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    i_rst = 1'b1;
    tick();
    set_regs(8'h10);

    // 0xAC before any packet: 17 zero bytes
    sent_log.delete();
    send_cmd(8'hAC, 1'b0);
    wait_idle("ac_empty_timeout");
    check("ac_empty_len", sent_log.size(), TB);
    check("ac_empty_b0", sent_log[0], 8'h00);
    check("ac_empty_b16", sent_log[16], 8'h00);

    // Regfile dump: 0x10..0x28 in address order
    sent_log.delete();
    send_cmd(8'hAB, 1'b0);
    wait_idle("ab_timeout");
    check("ab_len", sent_log.size(), FB);
    for (int j = 0; j < FB; j++) check("ab_literal", sent_log[j], 8'h10 + 8'(j));
    check("ab_busy_after", o_busy, 1'b0);

    // Thunderbolt dump. A new packet arriving mid-dump must not alter the dump.
    for (int k = 0; k < TB; k++) pkt_buf[k] = 8'h01 + 8'(k);
    thunder_pulse();
    sent_log.delete();
    send_cmd(8'hAC, 1'b0);
    wait_sent(5, "ac_mid_timeout");
    for (int k = 0; k < TB; k++) pkt_buf[k] = 8'hC0 + 8'(k);
    thunder_pulse();
    wait_idle("ac_timeout");
    check("ac_len", sent_log.size(), TB);
    check("ac_b0", sent_log[0], 8'h01);
    check("ac_b10", sent_log[10], 8'h0B);
    check("ac_b16", sent_log[16], 8'h11);

    // Packet arriving in the same cycle as 0xAC is the one dumped
    for (int k = 0; k < TB; k++) pkt_buf[k] = 8'h80 + 8'(k);
    sent_log.delete();
    send_cmd(8'hAC, 1'b1);
    wait_idle("ac_same_timeout");
    check("ac_same_b0", sent_log[0], 8'h80);
    check("ac_same_b16", sent_log[16], 8'h90);

    // 0xAC during a regfile dump is ignored; regfile changes mid-dump are ignored
    sent_log.delete();
    send_cmd(8'hAB, 1'b0);
    wait_sent(3, "ab_ign_timeout3");
    set_regs(8'hE0);
    send_cmd(8'hAC, 1'b0);
    wait_idle("ab_ign_timeout");
    check("ab_ign_len", sent_log.size(), FB);
    check("ab_ign_b3", sent_log[3], 8'h13);
    check("ab_ign_b24", sent_log[24], 8'h28);
    set_regs(8'h10);

    // Transmitter busy for 50 cycles holds off the first byte
    sent_log.delete();
    hold_active = 1'b1;
    send_cmd(8'hAB, 1'b0);
    repeat (50) tick();
    check("hold_no_tx", sent_log.size(), 0);
    check("hold_busy", o_busy, 1'b1);
    hold_active = 1'b0;
    wait_idle("hold_timeout");
    check("hold_len", sent_log.size(), FB);
    check("hold_b0", sent_log[0], 8'h10);

    // Reset after the 5th i_tx_done aborts the dump
    sent_log.delete();
    base = done_cnt;
    send_cmd(8'hAB, 1'b0);
    n = 0;
    while (done_cnt - base < 5 && n < 1000) begin
      tick();
      n++;
    end
    check("rst_mid_timeout", (n < 1000), 1'b1);
    i_rst = 1'b0;
    #1;
    check("rst_mid_tx_dv", o_tx_dv, 1'b0);
    check("rst_mid_busy", o_busy, 1'b0);
    exp_q.delete();
    accepted = done_cnt;
    repeat (3) tick();
    i_rst = 1'b1;
    repeat (100) tick();
    check("rst_mid_len", sent_log.size(), 5);

    // First command after reset release works normally
    sent_log.delete();
    send_cmd(8'hAB, 1'b0);
    wait_idle("post_rst_timeout");
    check("post_rst_len", sent_log.size(), FB);
    check("post_rst_b0", sent_log[0], 8'h10);

    // Unrecognised byte
    sent_log.delete();
    send_cmd(8'h55, 1'b0);
`ifdef BACKCHANNEL_ECHO_EN
    wait_idle("echo_timeout");
    check("echo_len", sent_log.size(), 1);
    check("echo_b0", sent_log[0], 8'h55);
`else
    repeat (20) tick();
    check("noecho_len", sent_log.size(), 0);
    check("noecho_busy", o_busy, 1'b0);
`endif

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
